// File: rtl/fft_ctrl_pkg.sv
// Shared constants for the FFT frame sequencer: FSM state encodings, error flag
// bit positions, config word layout and supported transform bounds.
package fft_ctrl_pkg;

    // Default transform size bounds (log2 of points)
    localparam int unsigned LOG2_NMAX_DEF = 10;
    localparam int unsigned LOG2_NMIN_DEF = 3;

    // Frame sequencer states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CFG    = 2'd1;
    localparam logic [1:0] ST_LOAD   = 2'd2;
    localparam logic [1:0] ST_UNLOAD = 2'd3;

    // Sticky error flag bit positions
    localparam int unsigned ERR_CFG_BAD      = 3;
    localparam int unsigned ERR_START_BUSY   = 2;
    localparam int unsigned ERR_EARLY_LAST   = 1;
    localparam int unsigned ERR_MISSING_LAST = 0;

    // Core config word layout: {scale_sch, fwd_inv}
    localparam int unsigned CFG_FWD_INV_BIT = 0;
    localparam int unsigned CFG_SCALE_LSB   = 1;

endpackage

// File: rtl/fft_beat_counter.sv
// Handshake-driven beat counter. The terminal value (N-1) is latched on load_i so
// the frame length cannot change while a frame is in flight; last_o flags the
// final beat and the count wraps back to zero on the final handshake.
module fft_beat_counter #(
    parameter int unsigned W = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] term_i,
    input  logic         hs_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] term_q, term_d;

    assign last_o = (cnt_q == term_q);

    // Next count and terminal value; clear beats a same-cycle handshake
    always_comb begin
        term_d = load_i ? term_i : term_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (hs_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            term_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame-level sequencer between the FFT register file and the FFT core streams.
// Latches a config on start, pushes it to the core, gates N samples in and N
// results out, generates TLAST and reports busy/done/err/frame_cnt.
// Optional: define FFT_FRAME_IRQ_EN to build the level interrupt output (irq);
// otherwise irq is tied low.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned LOG2_NMAX = LOG2_NMAX_DEF,
    parameter int unsigned LOG2_NMIN = LOG2_NMIN_DEF,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CFG_W     = 16
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        log2_n,
    input  logic              fwd_inv,
    input  logic [CFG_W-2:0]  scale_sch,
    output logic              cfg_tvalid,
    input  logic              cfg_tready,
    output logic [CFG_W-1:0]  cfg_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    output logic              fi_tvalid,
    input  logic              fi_tready,
    output logic [DATA_W-1:0] fi_tdata,
    output logic              fi_tlast,
    input  logic              fo_tvalid,
    output logic              fo_tready,
    input  logic [DATA_W-1:0] fo_tdata,
    input  logic              fo_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              busy,
    output logic              done,
    output logic [3:0]        err,
    input  logic              err_clr,
    output logic [15:0]       frame_cnt,
    output logic              irq
);

    logic [1:0]           state_q, state_d;
    logic [CFG_W-1:0]     cfg_q, cfg_d;
    logic [3:0]           err_q, err_d, err_set;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 done_q, done_d;

    logic                 idle, in_load, in_unload;
    logic                 cfg_ok, start_ok;
    logic                 fi_hs, m_hs, in_last, out_last, frame_end;
    logic [LOG2_NMAX:0]   n_full;
    logic [LOG2_NMAX-1:0] term;

    assign idle      = (state_q == ST_IDLE);
    assign in_load   = (state_q == ST_LOAD);
    assign in_unload = (state_q == ST_UNLOAD);

    assign cfg_ok   = (log2_n >= 5'(LOG2_NMIN)) && (log2_n <= 5'(LOG2_NMAX));
    assign start_ok = start && !abort && idle && cfg_ok;

    // N-1 from the requested size; only loaded into the counters when cfg_ok
    assign n_full = {{LOG2_NMAX{1'b0}}, 1'b1} << log2_n;
    assign term   = n_full[LOG2_NMAX-1:0] - 1'b1;

    // Stream gating: zero-latency passthrough only in the owning state
    assign cfg_tvalid = (state_q == ST_CFG);
    assign cfg_tdata  = cfg_q;
    assign fi_tvalid  = in_load & s_tvalid;
    assign s_tready   = in_load & fi_tready;
    assign fi_tdata   = s_tdata;
    assign fi_tlast   = in_load & in_last;
    assign m_tvalid   = in_unload & fo_tvalid;
    assign fo_tready  = in_unload & m_tready;
    assign m_tdata    = fo_tdata;
    assign m_tlast    = in_unload & out_last;

    assign fi_hs     = fi_tvalid & fi_tready;
    assign m_hs      = m_tvalid & m_tready;
    assign frame_end = m_hs & out_last & !abort;

    assign busy      = !idle;
    assign done      = done_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;

    fft_beat_counter #(
        .W (LOG2_NMAX)
    ) u_in_cnt (
        .clk_i  (ACLK),
        .rst_ni (ARESETN),
        .clr_i  (abort | start_ok),
        .load_i (start_ok),
        .term_i (term),
        .hs_i   (fi_hs),
        .last_o (in_last)
    );

    fft_beat_counter #(
        .W (LOG2_NMAX)
    ) u_out_cnt (
        .clk_i  (ACLK),
        .rst_ni (ARESETN),
        .clr_i  (abort | start_ok),
        .load_i (start_ok),
        .term_i (term),
        .hs_i   (m_hs),
        .last_o (out_last)
    );

    // FSM next state; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ok) state_d = ST_CFG;
            ST_CFG:    if (cfg_tready) state_d = ST_LOAD;
            ST_LOAD:   if (fi_hs && in_last) state_d = ST_UNLOAD;
            ST_UNLOAD: if (m_hs && out_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // Config capture, error flags, frame counter and done pulse
    always_comb begin
        cfg_d = cfg_q;
        if (start_ok) begin
            cfg_d[CFG_FWD_INV_BIT]         = fwd_inv;
            cfg_d[CFG_W-1:CFG_SCALE_LSB]   = scale_sch;
        end

        err_set                   = '0;
        err_set[ERR_CFG_BAD]      = start && !abort && idle && !cfg_ok;
        err_set[ERR_START_BUSY]   = start && !abort && !idle;
        err_set[ERR_EARLY_LAST]   = !abort && fi_hs && s_tlast && !in_last;
        err_set[ERR_MISSING_LAST] = !abort && ((fi_hs && in_last && !s_tlast) ||
                                               (m_hs && (fo_tlast != out_last)));
        // A flag raised in the same cycle as err_clr survives the clear
        err_d = (err_q & ~{4{err_clr}}) | err_set;

        frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
        done_d      = frame_end;
    end

    // Sequencer state registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            err_q       <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
        end
    end

`ifdef FFT_FRAME_IRQ_EN
    logic irq_q, irq_d, irq_set;

    // Level interrupt: set by done or a newly raised error, set beats clear
    always_comb begin
        irq_set = done_q | (|(err_set & ~err_q));
        irq_d   = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (err_clr || start) begin
            irq_d = 1'b0;
        end
    end

    // Interrupt level register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: directed frames push expected cfg words and
// beats into queues; a monitor pops and compares on every handshake. A small
// bench-side model plays the upstream source, an identity FFT core and the sink.
module tb_fft_frame_ctrl;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

`ifdef FFT_FRAME_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        start, abort, fwd_inv, err_clr;
    logic [4:0]  log2_n;
    logic [14:0] scale_sch;
    logic        cfg_tvalid, cfg_tready;
    logic [15:0] cfg_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic        fi_tvalid, fi_tready, fi_tlast;
    logic [31:0] fi_tdata;
    logic        fo_tvalid, fo_tready, fo_tlast;
    logic [31:0] fo_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic        busy, done, irq;
    logic [3:0]  err;
    logic [15:0] frame_cnt;

    beat_t       src_q[$];
    beat_t       exp_fi_q[$];
    beat_t       exp_m_q[$];
    logic [15:0] exp_cfg_q[$];
    logic [31:0] core_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int cfg_seen = 0;
    int fi_cnt = 0;
    int m_cnt = 0;
    int cur_n = 8;
    int core_out_cnt = 0;
    bit bp = 1'b0;

    always #5 ACLK = ~ACLK;

    fft_frame_ctrl u_dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .start      (start),
        .abort      (abort),
        .log2_n     (log2_n),
        .fwd_inv    (fwd_inv),
        .scale_sch  (scale_sch),
        .cfg_tvalid (cfg_tvalid),
        .cfg_tready (cfg_tready),
        .cfg_tdata  (cfg_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .fi_tvalid  (fi_tvalid),
        .fi_tready  (fi_tready),
        .fi_tdata   (fi_tdata),
        .fi_tlast   (fi_tlast),
        .fo_tvalid  (fo_tvalid),
        .fo_tready  (fo_tready),
        .fo_tdata   (fo_tdata),
        .fo_tlast   (fo_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_clr    (err_clr),
        .frame_cnt  (frame_cnt),
        .irq        (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Source, identity core and sink model; samples handshakes at negedge
    initial begin : bfm
        bit s_hs, fi_hs, fo_hs;
        logic [31:0] fi_d;
        s_tvalid = 0; s_tdata = 0; s_tlast = 0;
        fi_tready = 1; m_tready = 1; cfg_tready = 1;
        fo_tvalid = 0; fo_tdata = 0; fo_tlast = 0;
        forever begin
            @(negedge ACLK);
            s_hs  = s_tvalid && s_tready;
            fi_hs = fi_tvalid && fi_tready;
            fi_d  = fi_tdata;
            fo_hs = fo_tvalid && fo_tready;
            @(posedge ACLK);
            #1;
            if (s_hs && src_q.size() != 0) void'(src_q.pop_front());
            if (fi_hs) core_q.push_back(fi_d);
            if (fo_hs && core_q.size() != 0) begin
                void'(core_q.pop_front());
                core_out_cnt = (core_out_cnt == cur_n - 1) ? 0 : core_out_cnt + 1;
            end
            s_tvalid = (src_q.size() != 0);
            s_tdata  = (src_q.size() != 0) ? src_q[0].data : 32'h0;
            s_tlast  = (src_q.size() != 0) ? src_q[0].last : 1'b0;
            fo_tvalid = (core_q.size() != 0);
            fo_tdata  = (core_q.size() != 0) ? core_q[0] : 32'h0;
            fo_tlast  = (core_out_cnt == cur_n - 1);
            fi_tready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m_tready   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard monitor: pops and compares on every DUT-presented handshake
    initial begin : monitor
        beat_t       b;
        logic [15:0] c;
        forever begin
            @(negedge ACLK);
            if (done === 1'b1) done_cnt++;
            if (cfg_tvalid === 1'b1) cfg_seen++;
            if (cfg_tvalid && cfg_tready) begin
                if (exp_cfg_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL cfg_unexpected: got 0x%0h, expected no handshake", cfg_tdata);
                end else begin
                    c = exp_cfg_q.pop_front();
                    check("cfg_tdata", {16'h0, cfg_tdata}, {16'h0, c});
                end
            end
            if (fi_tvalid && fi_tready) begin
                fi_cnt++;
                if (exp_fi_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL fi_unexpected: got 0x%0h, expected no beat", fi_tdata);
                end else begin
                    b = exp_fi_q.pop_front();
                    check("fi_tdata", fi_tdata, b.data);
                    check("fi_tlast", {31'h0, fi_tlast}, {31'h0, b.last});
                end
            end
            if (m_tvalid && m_tready) begin
                m_cnt++;
                if (exp_m_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL m_unexpected: got 0x%0h, expected no beat", m_tdata);
                end else begin
                    b = exp_m_q.pop_front();
                    check("m_tdata", m_tdata, b.data);
                    check("m_tlast", {31'h0, m_tlast}, {31'h0, b.last});
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic prep_frame(input int fid, input int l2, input int tlast_beat,
                              input logic fwd, input logic [14:0] sch, input bit with_out);
        beat_t b;
        int    n = 1 << l2;
        cur_n = n;
        for (int i = 0; i < n; i++) begin
            b.data = {fid[7:0], 8'hC5, i[15:0]};
            b.last = (i == tlast_beat);
            src_q.push_back(b);
            b.last = (i == n - 1);
            exp_fi_q.push_back(b);
            if (with_out) exp_m_q.push_back(b);
        end
        exp_cfg_q.push_back({sch, fwd});
    endtask

    task automatic do_start(input int l2, input logic fwd, input logic [14:0] sch);
        @(posedge ACLK);
        #1;
        log2_n = l2[4:0]; fwd_inv = fwd; scale_sch = sch; start = 1'b1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
    endtask

    task automatic clear_err();
        @(posedge ACLK);
        #1;
        err_clr = 1'b1;
        @(posedge ACLK);
        #1;
        err_clr = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge ACLK);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, {31'h0, seen}, 32'h1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_fi_q"}, exp_fi_q.size(), 0);
        check({tag, "_m_q"}, exp_m_q.size(), 0);
        check({tag, "_cfg_q"}, exp_cfg_q.size(), 0);
    endtask

    initial begin : stim
        int snap_done, snap_cfg, snap_fi, snap_m, k;
        start = 0; abort = 0; err_clr = 0; log2_n = 0; fwd_inv = 0; scale_sch = 0;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_err", {28'h0, err}, 0);
        check("rst_frame_cnt", {16'h0, frame_cnt}, 0);
        check("rst_outs", {26'h0, cfg_tvalid, s_tready, m_tvalid, fo_tready, done, irq}, 0);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;

        // Clean 8-point forward frame
        prep_frame(1, 3, 7, 1'b1, 15'h2AB5, 1'b1);
        do_start(3, 1'b1, 15'h2AB5);
        wait_done(200, "t1_done");
        check("t1_irq_at_done", {31'h0, irq}, 0);
        @(negedge ACLK);
        check("t1_irq_after_done", {31'h0, irq}, {31'h0, IRQ_EXP});
        check("t1_frame_cnt", {16'h0, frame_cnt}, 1);
        check("t1_err", {28'h0, err}, 0);
        check("t1_busy", {31'h0, busy}, 0);
        check("t1_done_cnt", done_cnt, 1);
        check_drained("t1");
        clear_err();
        check("t1_irq_cleared", {31'h0, irq}, 0);

        // Out-of-range size: flagged, no config issued
        snap_cfg = cfg_seen;
        do_start(2, 1'b0, 15'h0);
        repeat (3) @(negedge ACLK);
        check("t2_err", {28'h0, err}, 32'h8);
        check("t2_busy", {31'h0, busy}, 0);
        check("t2_cfg_seen", cfg_seen, snap_cfg);
        clear_err();
        check("t2_err_clr", {28'h0, err}, 0);

        // 16-point inverse frame, early s_tlast, plus a start while busy
        prep_frame(2, 4, 5, 1'b0, 15'h0011, 1'b1);
        do_start(4, 1'b0, 15'h0011);
        repeat (3) @(posedge ACLK);
        do_start(3, 1'b1, 15'h0);
        wait_done(400, "t3_done");
        repeat (2) @(negedge ACLK);
        check("t3_err", {28'h0, err}, 32'h7);
        check("t3_frame_cnt", {16'h0, frame_cnt}, 2);
        check("t3_done_cnt", done_cnt, 2);
        check_drained("t3");
        clear_err();
        check("t3_err_clr", {28'h0, err}, 0);
        check("t3_irq_clr", {31'h0, irq}, 0);

        // 1024-point frame under random backpressure
        snap_fi = fi_cnt;
        snap_m  = m_cnt;
        bp = 1'b1;
        prep_frame(3, 10, 1023, 1'b1, 15'h7FFF, 1'b1);
        do_start(10, 1'b1, 15'h7FFF);
        wait_done(30000, "t4_done");
        bp = 1'b0;
        repeat (3) @(negedge ACLK);
        check("t4_fi_beats", fi_cnt - snap_fi, 1024);
        check("t4_m_beats", m_cnt - snap_m, 1024);
        check("t4_frame_cnt", {16'h0, frame_cnt}, 3);
        check("t4_done_cnt", done_cnt, 3);
        check("t4_err", {28'h0, err}, 0);
        check_drained("t4");

        // Abort during LOAD after three beats
        cur_n = 8;
        begin
            beat_t b;
            for (int i = 0; i < 3; i++) begin
                b.data = {8'h04, 8'hAB, i[15:0]};
                b.last = 1'b0;
                src_q.push_back(b);
                exp_fi_q.push_back(b);
            end
        end
        exp_cfg_q.push_back({15'h0003, 1'b1});
        snap_done = done_cnt;
        do_start(3, 1'b1, 15'h0003);
        k = 0;
        for (int c = 0; c < 200 && k < 3; c++) begin
            @(negedge ACLK);
            if (fi_tvalid && fi_tready) k++;
        end
        check("t5_three_beats", k, 3);
        @(posedge ACLK);
        #1;
        abort = 1'b1;
        @(posedge ACLK);
        #1;
        abort = 1'b0;
        @(negedge ACLK);
        check("t5_busy", {31'h0, busy}, 0);
        check("t5_s_tready", {31'h0, s_tready}, 0);
        core_q.delete();
        core_out_cnt = 0;
        repeat (3) @(negedge ACLK);
        check("t5_no_done", done_cnt, snap_done);
        check("t5_frame_cnt", {16'h0, frame_cnt}, 3);
        check_drained("t5");

        // Clean frame after abort
        prep_frame(5, 3, 7, 1'b0, 15'h1234, 1'b1);
        do_start(3, 1'b0, 15'h1234);
        wait_done(200, "t6_done");
        repeat (2) @(negedge ACLK);
        check("t6_frame_cnt", {16'h0, frame_cnt}, 4);
        check("t6_err", {28'h0, err}, 0);
        check("t6_done_cnt", done_cnt, snap_done + 1);
        check_drained("t6");

        // Reset mid-frame clears state, err and frame_cnt
        do_start(2, 1'b0, 15'h0);
        exp_cfg_q.push_back({15'h0055, 1'b1});
        cur_n = 8;
        do_start(3, 1'b1, 15'h0055);
        repeat (3) @(negedge ACLK);
        check("t7_busy_before", {31'h0, busy}, 1);
        ARESETN = 1'b0;
        #1;
        check("t7_rst_busy", {31'h0, busy}, 0);
        check("t7_rst_err", {28'h0, err}, 0);
        check("t7_rst_frame_cnt", {16'h0, frame_cnt}, 0);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        check_drained("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Frame-level sequencer between the myip_fft AXI4-Lite register file and the FFT core's AXI-Stream ports.
- Latches a transform configuration on software start and pushes it through the core config channel.
- Then gates exactly N input samples into the core and N results out of it, generates core TLAST, and reports busy, done and error status back to the registers.

Parameters:
- LOG2_NMAX, 10: largest supported transform, log2 of points.
- LOG2_NMIN, 3: smallest supported transform.
- DATA_W, 32: sample width, {im[15:0], re[15:0]}.
- CFG_W, 16: core config word width.

Ports:
- ACLK in 1: clock.
- ARESETN in 1: asynchronous active-low reset.
- start in 1: one-cycle pulse from CTRL register write.
- abort in 1: one-cycle pulse, cancels the current frame.
- log2_n in 5: transform size, sampled on start.
- fwd_inv in 1: 1 = forward, sampled on start.
- scale_sch in CFG_W-1: scaling schedule, sampled on start.
- cfg_tvalid out 1: config channel valid to the core.
- cfg_tready in 1: config channel ready from the core.
- cfg_tdata out CFG_W: {scale_sch, fwd_inv}.
- s_tvalid in 1, s_tready out 1, s_tdata in DATA_W, s_tlast in 1: upstream sample stream.
- fi_tvalid out 1, fi_tready in 1, fi_tdata out DATA_W, fi_tlast out 1: core input.
- fo_tvalid in 1, fo_tready out 1, fo_tdata in DATA_W, fo_tlast in 1: core output.
- m_tvalid out 1, m_tready in 1, m_tdata out DATA_W, m_tlast out 1: downstream result stream.
- busy out 1: state != IDLE.
- done out 1: one-cycle pulse at frame completion.
- err out 4: sticky flags {cfg_bad, start_busy, early_last, missing_last}.
- err_clr in 1: clears err.
- frame_cnt out 16: completed frames, wraps at 0xFFFF->0.
- irq out 1: see Optional Feature.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States: IDLE, CFG, LOAD, UNLOAD.
- IDLE, start asserted:
  - log2_n outside [LOG2_NMIN, LOG2_NMAX]: set err[3], stay in IDLE.
  - Otherwise: latch N = 1<<log2_n and the config, go to CFG.
- CFG:
  - cfg_tvalid = 1, cfg_tdata held stable until cfg_tready.
  - On the handshake cycle, go to LOAD.
- LOAD:
  - fi_tvalid = s_tvalid, s_tready = fi_tready, fi_tdata = s_tdata (combinational, zero latency).
  - in_cnt increments on each fi handshake. fi_tlast = (in_cnt == N-1), independent of s_tlast.
  - s_tlast=1 accepted with in_cnt < N-1: set err[1]; the frame continues.
  - s_tlast=0 on the final beat: set err[0].
  - After the final beat, go to UNLOAD.
- Outside LOAD: s_tready = 0 and fi_tvalid = 0.
- UNLOAD:
  - m_* = fo_* passthrough, fo_tready = m_tready.
  - out_cnt counts handshakes. m_tlast = (out_cnt == N-1). A core fo_tlast mismatch sets err[0].
  - Final beat handshake: done = 1 for one cycle, frame_cnt++, go to IDLE.
- Outside UNLOAD: fo_tready = 0, m_tvalid = 0.
- start while busy: ignored, set err[2].
- abort in any state: next cycle IDLE, counters cleared, all valids and readies 0, no done pulse. Abort has priority over a same-cycle start or handshake.
- err_clr and a same-cycle flag set: set wins.
- ARESETN low mid-frame: immediate return to IDLE; err and frame_cnt cleared.
- Counter widths: LOG2_NMAX bits. N-1 comparison uses the latched log2_n.

Optional Feature:
- Macro: FFT_FRAME_IRQ_EN.
- Defined:
  - irq is a level, set by done or by any err bit rising.
  - Cleared by err_clr or start. Set wins over clear.
- Undefined: irq tied to 0, no irq logic.

Decomposition:
- fft_ctrl_pkg:
  - state enum.
  - err bit index constants: ERR_CFG_BAD=3, ERR_START_BUSY=2, ERR_EARLY_LAST=1, ERR_MISSING_LAST=0.
  - cfg word field offsets.
  - LOG2 bounds.
- Sub-module fft_beat_counter:
  - Handshake-driven counter with clear, latched terminal value and last flag.
  - Instantiated twice (in and out).

Test Plan:
- log2_n=3, fwd_inv=1, start, 8 samples with s_tlast on beat 7:
  - one cfg handshake with cfg_tdata[0]=1.
  - fi_tlast only on beat 7 and m_tlast only on beat 7.
  - done pulse, frame_cnt=1, err=0.
- log2_n=2 start -> err=4'b1000, busy stays 0, cfg_tvalid never asserted.
- log2_n=4, s_tlast on beat 5:
  - err[1]=1, fi_tlast still on beat 15, frame completes.
  - err_clr -> err=0.
- Random fi_tready/m_tready backpressure (50%), log2_n=10: exactly 1024 beats each way, no data loss, done once.
- abort during LOAD at in_cnt=3:
  - next cycle busy=0, s_tready=0, no done.
  - A following start runs a clean frame.
- FFT_FRAME_IRQ_EN defined: irq rises the cycle after done and falls on err_clr. Undefined: irq constant 0.
